load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the multi-cycle core and the byte-addressed `Memory` block and owns every data access. It accepts one load/store request per handshake and extracts and sign/zero-extends load data. Because `Memory` only writes whole 32-bit words, it performs read-modify-write for byte and halfword stores. It also detects out-of-range and (optionally) misaligned accesses, which it reports as errors without touching memory.

## Interface
- `MEM_BYTES`, 4096: size of the attached memory in bytes.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: core presents a request.
- `req_ready` output 1: unit can accept; high only in IDLE.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32I access type.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, low-aligned.
- `resp_valid` output 1: response available.
- `resp_ready` input 1: core consumes response.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: access rejected.
- `mem_address` output 32: to `Memory.address`.
- `mem_write_data` output 32: to `Memory.write_data`.
- `mem_write_enable` output 1: to `Memory.write_enable`.
- `mem_read_data` input 32: from `Memory.read_data`, combinational on `mem_address`.

## Operation
- States:
  - IDLE
  - READ
  - WRITE
  - RESP
- The request fires on `req_valid && req_ready`. On fire it latches `we`, `funct3`, `addr` and `wdata`.
- Validity checks are evaluated on fire. Any failure goes to RESP with `resp_err=1` and performs no memory access.
  - Illegal encoding. Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000, 001, 010.
  - Out of range: `addr > MEM_BYTES-4`. Memory always touches 4 bytes, and the comparison is unsigned 32-bit.
  - Misaligned, when enabled (see Configuration).
- Valid load: IDLE→READ. In READ, capture `mem_read_data` into the data register → RESP.
- Valid SW: IDLE→WRITE. `mem_write_data = wdata` with `mem_write_enable=1` for exactly one cycle → RESP.
- Valid SB/SH: IDLE→READ, capturing the old word. Then → WRITE with the merged word:
  - SB replaces byte [7:0] with `wdata[7:0]`.
  - SH replaces bytes [15:0] with `wdata[15:0]`.
  - Remaining bytes are kept.
- `mem_address` equals the latched `addr` in READ and WRITE and 0 otherwise. Memory is byte-addressed, so no lane shifting is done.
- Load extraction from the captured word `w`:
  - LB: sign-extend `w[7:0]`.
  - LBU: zero-extend `w[7:0]`.
  - LH: sign-extend `w[15:0]`.
  - LHU: zero-extend `w[15:0]`.
  - LW: `w`.
- RESP holds `resp_valid`, `resp_rdata` and `resp_err` stable until `resp_ready`. Then → IDLE.
- Reset (any cycle, including mid-WRITE): asynchronously forces IDLE and drops `mem_write_enable` immediately. An in-flight store may be lost.

## Timing
- Reset values:
  - `req_ready=1`
  - `resp_valid=0`
  - `resp_err=0`
  - `resp_rdata=0`
  - `mem_address=0`
  - `mem_write_data=0`
  - `mem_write_enable=0`
- Request fire edge = cycle 0. Earliest `resp_valid` cycle:
  - Load: cycle 2 (READ in cycle 1).
  - SW: cycle 2 (WRITE in cycle 1).
  - SB/SH: cycle 3 (READ in 1, WRITE in 2).
  - Error: cycle 1.
- The memory write commits on the edge ending WRITE, so it is visible to any later request.
- `resp_ready` may be high before `resp_valid`. Response and IDLE return take one edge, and the next request can fire the cycle after.
- No request is accepted while a response is pending. `req_ready=0` in READ, WRITE and RESP.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: halfword with `addr[0]=1`, or word with `addr[1:0]!=0`, returns `resp_err=1` with no access.
- Macro undefined: misaligned accesses proceed normally at the byte address, since `Memory` supports any byte alignment.

## Structure
- `lsu_pkg` holds:
  - the state enum `lsu_state_t`
  - the funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`)
  - helper `lsu_size_bytes`
- Sub-module `lsu_align`: purely combinational. Contains the store merge (old word, wdata, funct3 → new word) and the load extract (word, funct3 → rdata). The FSM stays in `load_store_unit`.

## Test plan
- Memory preloaded with word 0x8899AABB at addr 0x10; LB, LBU, LH, LHU and LW issued at 0x10 → rdata 0xFFFFFFBB, 0x000000BB, 0xFFFFAABB, 0x0000AABB and 0x8899AABB, each with resp_valid at cycle 2.
- With the same word at 0x10, SB 0x12345677 to 0x10 then LW at 0x10 → 0x8899AA77. A following SH 0x0000CAFE then LW → 0x8899CAFE. Each store shows `mem_write_enable` high for exactly one cycle.
- LW at 0xFFD (MEM_BYTES=4096) → resp_err=1 at cycle 1, and `mem_write_enable` never asserts. SW at 0xFFC succeeds.
- LH at 0x11: with `LSU_MISALIGN_TRAP_EN` → resp_err=1. Without it → half formed from bytes 0x11–0x12.
- resp_ready held low 5 cycles → resp_valid and rdata stay stable and req_ready stays 0. Releasing it returns to IDLE in one edge.
- rst_n pulsed low during the WRITE of an SB → `mem_write_enable` drops asynchronously, then idle outputs at reset values and req_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RV32I funct3 access codes and the access-size helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_READ  = 2'd1,
        LSU_WRITE = 2'd2,
        LSU_RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Bytes touched by an access of this funct3; unknown codes report a word.
    function automatic logic [2:0] lsu_size_bytes(input logic [2:0] funct3);
        logic [2:0] size;
        case (funct3)
            F3_B, F3_BU: size = 3'd1;
            F3_H, F3_HU: size = 3'd2;
            default:     size = 3'd4;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake plus the word-wide Memory port.
// slave = the load/store unit, master = core and memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_write_data, mem_write_enable
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational data path of the load/store unit: merges store data into the
// old memory word and extracts/extends load data from a memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_merged,
    output logic [31:0] o_rdata
);

    // Memory is byte-addressed, so the addressed byte is always lane 0.
    always_comb begin
        o_merged = i_wdata;
        case (lsu_size_bytes(i_funct3))
            3'd1:    o_merged = {i_word[31:8], i_wdata[7:0]};
            3'd2:    o_merged = {i_word[31:16], i_wdata[15:0]};
            default: o_merged = i_wdata;
        endcase
    end

    always_comb begin
        o_rdata = i_word;
        case (i_funct3)
            F3_B:    o_rdata = {{24{i_word[7]}}, i_word[7:0]};
            F3_BU:   o_rdata = {24'd0, i_word[7:0]};
            F3_H:    o_rdata = {{16{i_word[15]}}, i_word[15:0]};
            F3_HU:   o_rdata = {16'd0, i_word[15:0]};
            default: o_rdata = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit FSM: request validation, load extraction and read-modify-write
// for sub-word stores. Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    lsu_state_t  r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_legal;
    logic        w_range_err;
    logic        w_misalign;
    logic        w_reject;
    logic [31:0] w_merged;
    logic [31:0] w_extract;

    lsu_align u_align (
        .i_funct3 (r_funct3),
        .i_word   (bus.mem_read_data),
        .i_wdata  (r_wdata),
        .o_merged (w_merged),
        .o_rdata  (w_extract)
    );

    always_comb begin
        w_legal = 1'b0;
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: w_legal = 1'b1;
            F3_BU, F3_HU:     w_legal = !bus.req_we;
            default:          w_legal = 1'b0;
        endcase
    end

    // Memory always touches four bytes, so the last legal address is MEM_BYTES-4.
    assign w_range_err = (bus.req_addr > MAX_ADDR);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        w_misalign = 1'b0;
        case (lsu_size_bytes(bus.req_funct3))
            3'd2:    w_misalign = bus.req_addr[0];
            3'd4:    w_misalign = |bus.req_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_reject = !w_legal || w_range_err || w_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= LSU_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_word   <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (bus.req_valid) begin
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_word   <= bus.req_wdata;
                        r_rdata  <= 32'd0;
                        r_err    <= w_reject;
                        if (w_reject) begin
                            r_state <= LSU_RESP;
                        end else if (bus.req_we && bus.req_funct3 == F3_W) begin
                            r_state <= LSU_WRITE;
                        end else begin
                            r_state <= LSU_READ;
                        end
                    end
                end
                // Loads capture extended data; sub-word stores capture the merged word.
                LSU_READ: begin
                    if (r_we) begin
                        r_word  <= w_merged;
                        r_state <= LSU_WRITE;
                    end else begin
                        r_rdata <= w_extract;
                        r_state <= LSU_RESP;
                    end
                end
                LSU_WRITE: begin
                    r_state <= LSU_RESP;
                end
                LSU_RESP: begin
                    if (bus.resp_ready) begin
                        r_state <= LSU_IDLE;
                    end
                end
                default: begin
                    r_state <= LSU_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready        = (r_state == LSU_IDLE);
    assign bus.resp_valid       = (r_state == LSU_RESP);
    assign bus.resp_rdata       = (r_state == LSU_RESP) ? r_rdata : 32'd0;
    assign bus.resp_err         = (r_state == LSU_RESP) && r_err;
    assign bus.mem_address      = (r_state == LSU_READ || r_state == LSU_WRITE) ? r_addr : 32'd0;
    assign bus.mem_write_data   = (r_state == LSU_WRITE) ? r_word : 32'd0;
    assign bus.mem_write_enable = (r_state == LSU_WRITE);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, byte-level reference model and
// a per-cycle compare process, plus hand-computed literal expectations.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_BYTES(4096)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [0:4095];
    logic [7:0] ref_mem [0:4095];

    assign bus.mem_read_data = {mem[12'(bus.mem_address + 32'd3)], mem[12'(bus.mem_address + 32'd2)],
                                mem[12'(bus.mem_address + 32'd1)], mem[12'(bus.mem_address)]};

    always @(posedge clk) begin
        if (bus.mem_write_enable) begin
            for (int k = 0; k < 4; k++) begin
                mem[12'(bus.mem_address + 32'(k))] <= bus.mem_write_data[8*k +: 8];
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fire_neg = 0;
    int we_pulses = 0;
    bit busy = 1'b0;
    bit resp_seen = 1'b0;
    bit chk_en = 1'b0;

    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wword;
    logic [31:0] exp_addr;
    int          exp_lat;
    int          exp_writes;

    logic [31:0] got_rdata;
    logic        got_err;
    int          got_lat;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic finish_sim();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[12'(a + 32'd3)], ref_mem[12'(a + 32'd2)], ref_mem[12'(a + 32'd1)], ref_mem[12'(a)]};
    endfunction

    // Reference: decide the outcome from the access rules and a flat byte memory.
    task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bit legal;
        bit bad;
        int n;
        logic [31:0] w;
        legal = we ? (f3 inside {3'b000, 3'b001, 3'b010}) : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        bad = !legal || (a > 32'd4092);
`ifdef LSU_MISALIGN_TRAP_EN
        if (n == 2 && a[0]) bad = 1'b1;
        if (n == 4 && a[1:0] != 2'b00) bad = 1'b1;
`endif
        exp_addr   = a;
        exp_rdata  = 32'd0;
        exp_err    = bad;
        exp_writes = 0;
        exp_wword  = 32'd0;
        if (bad) begin
            exp_lat = 1;
        end else if (!we) begin
            w = ref_word(a);
            if (n == 1)      exp_rdata = f3[2] ? {24'd0, w[7:0]}  : 32'($signed(w[7:0]));
            else if (n == 2) exp_rdata = f3[2] ? {16'd0, w[15:0]} : 32'($signed(w[15:0]));
            else             exp_rdata = w;
            exp_lat = 2;
        end else begin
            for (int i = 0; i < n; i++) ref_mem[12'(a + 32'(i))] = wd[8*i +: 8];
            exp_wword  = ref_word(a);
            exp_writes = 1;
            exp_lat    = (n == 4) ? 2 : 3;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            cyc++;
            check1("req_ready", bus.req_ready, !busy);
            if (!busy) begin
                check1("idle_resp_valid", bus.resp_valid, 1'b0);
                check1("idle_write_enable", bus.mem_write_enable, 1'b0);
            end
            if (bus.req_valid && bus.req_ready) begin
                busy = 1'b1;
                fire_neg = cyc;
                resp_seen = 1'b0;
                we_pulses = 0;
            end
            if (bus.mem_write_enable) begin
                we_pulses++;
                check32("write_address", bus.mem_address, exp_addr);
                check32("write_data", bus.mem_write_data, exp_wword);
            end
            if (bus.resp_valid) begin
                if (!resp_seen) begin
                    resp_seen = 1'b1;
                    got_lat   = cyc - fire_neg;
                    got_rdata = bus.resp_rdata;
                    got_err   = bus.resp_err;
                    check32("resp_cycle", 32'(got_lat), 32'(exp_lat));
                end
                check32("resp_rdata", bus.resp_rdata, exp_rdata);
                check1("resp_err", bus.resp_err, exp_err);
                if (bus.resp_ready) begin
                    check32("write_pulses", 32'(we_pulses), 32'(exp_writes));
                    busy = 1'b0;
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input int hold, input logic [31:0] lit_rdata, input logic lit_err, input int lit_lat);
        int t;
        @(posedge clk); #1;
        model_req(we, f3, a, wd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.resp_ready = (hold == 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        t = 0;
        while (!resp_seen) begin
            @(posedge clk); #1;
            t++;
            if (t > 40) begin
                $display("FAIL resp_timeout: got no resp_valid expected one within 40 cycles");
                errors++;
                checks++;
                finish_sim();
            end
        end
        repeat (hold) @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        t = 0;
        while (busy) begin
            @(posedge clk); #1;
            t++;
            if (t > 40) begin
                $display("FAIL handshake_timeout: got busy expected idle within 40 cycles");
                errors++;
                checks++;
                finish_sim();
            end
        end
        bus.resp_ready = 1'b0;
        check32("lit_rdata", got_rdata, lit_rdata);
        check1("lit_err", got_err, lit_err);
        check32("lit_cycle", 32'(got_lat), 32'(lit_lat));
        $display("txn we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d cycle=%0d",
                 we, f3, a, wd, got_rdata, got_err, got_lat);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] <= 8'h00;
            ref_mem[i] = 8'h00;
        end
        mem[16] <= 8'hBB; mem[17] <= 8'hAA; mem[18] <= 8'h99; mem[19] <= 8'h88;
        ref_mem[16] = 8'hBB; ref_mem[17] = 8'hAA; ref_mem[18] = 8'h99; ref_mem[19] = 8'h88;
        mem[32] <= 8'h44; mem[33] <= 8'h33; mem[34] <= 8'h22; mem[35] <= 8'h11;
        ref_mem[32] = 8'h44; ref_mem[33] = 8'h33; ref_mem[34] = 8'h22; ref_mem[35] = 8'h11;

        #12;
        check1("rst_req_ready", bus.req_ready, 1'b1);
        check1("rst_resp_valid", bus.resp_valid, 1'b0);
        check1("rst_resp_err", bus.resp_err, 1'b0);
        check32("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check32("rst_mem_address", bus.mem_address, 32'd0);
        check32("rst_mem_write_data", bus.mem_write_data, 32'd0);
        check1("rst_mem_write_enable", bus.mem_write_enable, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Loads of 0x8899AABB at 0x10
        do_req(1'b0, F3_B,  32'h10, 32'd0, 0, 32'hFFFFFFBB, 1'b0, 2);
        do_req(1'b0, F3_BU, 32'h10, 32'd0, 0, 32'h000000BB, 1'b0, 2);
        do_req(1'b0, F3_H,  32'h10, 32'd0, 0, 32'hFFFFAABB, 1'b0, 2);
        do_req(1'b0, F3_HU, 32'h10, 32'd0, 0, 32'h0000AABB, 1'b0, 2);
        do_req(1'b0, F3_W,  32'h10, 32'd0, 0, 32'h8899AABB, 1'b0, 2);

        // Read-modify-write stores
        do_req(1'b1, F3_B,  32'h10, 32'h12345677, 0, 32'd0, 1'b0, 3);
        do_req(1'b0, F3_W,  32'h10, 32'd0,        0, 32'h8899AA77, 1'b0, 2);
        do_req(1'b1, F3_H,  32'h10, 32'h0000CAFE, 0, 32'd0, 1'b0, 3);
        do_req(1'b0, F3_W,  32'h10, 32'd0,        0, 32'h8899CAFE, 1'b0, 2);

        // Range boundary and illegal encodings
        do_req(1'b0, F3_W,  32'hFFD, 32'd0,        0, 32'd0, 1'b1, 1);
        do_req(1'b1, F3_W,  32'hFFC, 32'hDEADBEEF, 0, 32'd0, 1'b0, 2);
        do_req(1'b0, F3_W,  32'hFFC, 32'd0,        0, 32'hDEADBEEF, 1'b0, 2);
        do_req(1'b0, F3_W,  32'hFFFFFFFC, 32'd0,   0, 32'd0, 1'b1, 1);
        do_req(1'b0, 3'b011, 32'h10, 32'd0,        0, 32'd0, 1'b1, 1);
        do_req(1'b1, F3_BU, 32'h10, 32'h000000FF,  0, 32'd0, 1'b1, 1);

        // Misaligned halfword at 0x11 (bytes 0xCA, 0x99)
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(1'b0, F3_H, 32'h11, 32'd0, 0, 32'd0, 1'b1, 1);
`else
        do_req(1'b0, F3_H, 32'h11, 32'd0, 0, 32'hFFFF99CA, 1'b0, 2);
`endif

        // Response back-pressure
        do_req(1'b0, F3_W, 32'h10, 32'd0, 5, 32'h8899CAFE, 1'b0, 2);

        // Reset during the WRITE of an SB: the store is lost
        @(posedge clk); #1;
        chk_en = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_B;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'hAAAAAA55;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check1("rmw_write_phase", bus.mem_write_enable, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("async_rst_write_enable", bus.mem_write_enable, 1'b0);
        check1("async_rst_req_ready", bus.req_ready, 1'b1);
        check32("async_rst_mem_address", bus.mem_address, 32'd0);
        check32("async_rst_mem_write_data", bus.mem_write_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.resp_ready = 1'b0;
        check1("post_rst_resp_valid", bus.resp_valid, 1'b0);
        check1("post_rst_req_ready", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        chk_en = 1'b1;
        do_req(1'b0, F3_W, 32'h20, 32'd0, 0, 32'h11223344, 1'b0, 2);

        finish_sim();
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1, "global timeout");
    end

endmodule
